// File: rtl/rb_seq_ctrl.sv
// rb_seq_ctrl: micro-sequencer for the 16x64-bit complex register bank and
// the complex ALU next to it. It fetches 24-bit instructions from a
// synchronous program ROM and sequences bank reads, ALU start/done
// handshakes and bank write-backs.
//
// Ports:
//   clock, reset          master clock (posedge), synchronous active-high reset
//   start, start_addr     launch execution at start_addr (accepted in IDLE only)
//   busy, done, err       status: busy outside IDLE, one-cycle done pulse,
//                         sticky error flag (cleared on accepted start)
//   prog_addr, prog_data  program ROM address (= pc) and read data (1-cycle latency)
//   alu_start, alu_done   ALU launch pulse / ALU result-valid input
//   regwen, selwreg,      bank write enable, write index and write mode
//   endreg
//   seloutA/B, cnstA/B    bank read indices and constant selects
//   enrregA/B             bank output register load strobes
//
// All outputs are registered: each is decoded from the next-state values so
// that it is valid during the cycle the sequencer spends in that state.
module rb_seq_ctrl #(
    parameter int PC_WIDTH = 6,
    parameter int TMO_CYC  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [23:0]         prog_data,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                regwen,
    output logic [3:0]          selwreg,
    output logic [1:0]          endreg,
    output logic [3:0]          seloutA,
    output logic [3:0]          seloutB,
    output logic                cnstA,
    output logic                cnstB,
    output logic                enrregA,
    output logic                enrregB
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_RDW    = 3'd4;
    localparam logic [2:0] S_ALU    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_READ = 3'b001;
    localparam logic [2:0] OP_EXEC = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [2:0]          state_r, state_nxt_s;
    logic [PC_WIDTH-1:0] pc_r, pc_nxt_s, pc_inc_s;
    logic [23:0]         ir_r, ir_nxt_s;
    logic                err_r, err_nxt_s;
    logic [TMO_W-1:0]    tmo_r, tmo_nxt_s;

    logic                busy_r, done_r, alu_start_r, regwen_r;
    logic                enrreg_a_r, enrreg_b_r, cnst_a_r, cnst_b_r;
    logic [3:0]          selwreg_r, selout_a_r, selout_b_r;
    logic [1:0]          endreg_r;

    // Low five instruction bits carry no meaning for the sequencer.
    logic                unused_ir_bits_s;
    assign unused_ir_bits_s = ^ir_r[4:0];

    // Wrapping program-counter increment.
    assign pc_inc_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Next-state, pc, ir, error and timeout computation.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        err_nxt_s   = err_r;
        tmo_nxt_s   = tmo_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    pc_nxt_s    = start_addr;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_nxt_s = S_DECODE;
            end
            S_DECODE: begin
                // ROM data is valid now; branch on it directly while latching ir.
                ir_nxt_s = prog_data;
                case (prog_data[23:21])
                    OP_NOP: begin
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = S_FETCH;
                    end
                    OP_READ, OP_EXEC: state_nxt_s = S_RD;
                    OP_SWAP:          state_nxt_s = S_WB;
                    OP_HALT:          state_nxt_s = S_DONE;
                    default: begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = S_DONE;
                    end
                endcase
            end
            S_RD: begin
                if (ir_r[23:21] == OP_EXEC) begin
                    state_nxt_s = S_RDW;
                end else begin
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = S_FETCH;
                end
            end
            S_RDW: begin
                tmo_nxt_s   = {TMO_W{1'b0}};
                state_nxt_s = S_ALU;
            end
            S_ALU: begin
                // tmo_r==0 marks the launch cycle, where alu_done is not trusted.
                if ((tmo_r != {TMO_W{1'b0}}) && alu_done) begin
                    state_nxt_s = S_WB;
                end else if (tmo_r == TMO_LAST) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = S_DONE;
                end else begin
                    tmo_nxt_s   = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    state_nxt_s = S_ALU;
                end
            end
            S_WB: begin
                pc_nxt_s    = pc_inc_s;
                state_nxt_s = S_FETCH;
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State registers and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pc_r        <= {PC_WIDTH{1'b0}};
            ir_r        <= 24'd0;
            err_r       <= 1'b0;
            tmo_r       <= {TMO_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            alu_start_r <= 1'b0;
            regwen_r    <= 1'b0;
            selwreg_r   <= 4'd0;
            endreg_r    <= 2'b00;
            selout_a_r  <= 4'd0;
            selout_b_r  <= 4'd0;
            cnst_a_r    <= 1'b0;
            cnst_b_r    <= 1'b0;
            enrreg_a_r  <= 1'b0;
            enrreg_b_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            err_r       <= err_nxt_s;
            tmo_r       <= tmo_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
            done_r      <= (state_nxt_s == S_DONE);
            alu_start_r <= (state_nxt_s == S_ALU) && (state_r != S_ALU);
            enrreg_a_r  <= (state_nxt_s == S_RD);
            enrreg_b_r  <= (state_nxt_s == S_RD);
            if (state_nxt_s == S_WB) begin
                regwen_r  <= 1'b1;
                selwreg_r <= ir_nxt_s[20:17];
                // SWAP always writes in swap mode whatever its endw field says.
                endreg_r  <= (ir_nxt_s[23:21] == OP_SWAP) ? 2'b11 : ir_nxt_s[16:15];
            end else begin
                regwen_r  <= 1'b0;
                selwreg_r <= 4'd0;
                endreg_r  <= 2'b00;
            end
            if (state_nxt_s != S_IDLE) begin
                cnst_a_r   <= ir_nxt_s[14];
                selout_a_r <= ir_nxt_s[13:10];
                cnst_b_r   <= ir_nxt_s[9];
                selout_b_r <= ir_nxt_s[8:5];
            end else begin
                cnst_a_r   <= 1'b0;
                selout_a_r <= 4'd0;
                cnst_b_r   <= 1'b0;
                selout_b_r <= 4'd0;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign prog_addr = pc_r;
    assign alu_start = alu_start_r;
    assign regwen    = regwen_r;
    assign selwreg   = selwreg_r;
    assign endreg    = endreg_r;
    assign seloutA   = selout_a_r;
    assign seloutB   = selout_b_r;
    assign cnstA     = cnst_a_r;
    assign cnstB     = cnst_b_r;
    assign enrregA   = enrreg_a_r;
    assign enrregB   = enrreg_b_r;

endmodule
